// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the word-to-byte serializer.
package byte_serializer_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Hold-register layout: byte 0 (first emitted) sits in the top lane.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [BYTE_W-1:0] b1,
    input logic [BYTE_W-1:0] b2,
    input logic [BYTE_W-1:0] b3,
    input logic [BYTE_W-1:0] b4,
    input logic              lsb_first
  );
    return lsb_first ? {b4, b3, b2, b1} : {b1, b2, b3, b4};
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Input word handshake and output byte stream of the serializer.
interface byte_serializer_if #(
  parameter int CNT_W = 16
);
  import byte_serializer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] B1;
  logic [BYTE_W-1:0] B2;
  logic [BYTE_W-1:0] B3;
  logic [BYTE_W-1:0] B4;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [CNT_W-1:0]  word_cnt;

  modport slave (
    input  in_valid, B1, B2, B3, B4, out_ready,
    output in_ready, out_data, out_valid, out_last, word_cnt
  );

  modport master (
    output in_valid, B1, B2, B3, B4, out_ready,
    input  in_ready, out_data, out_valid, out_last, word_cnt
  );

endinterface

// File: rtl/byte_serializer_byte_mux.sv
// 4:1 byte select out of the hold register, lane 0 in the top byte.
module byte_serializer_byte_mux
  import byte_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  sel,
  output logic [BYTE_W-1:0] data
);

  always_comb begin
    data = '0;
    case (sel)
      2'd0: data = word[31:24];
      2'd1: data = word[23:16];
      2'd2: data = word[15:8];
      2'd3: data = word[7:0];
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/byte_serializer.sv
// Captures one 4-byte word and emits it one byte per cycle with end-of-word marker.
//   state   | meaning
//   ST_IDLE | no word held, ready for a new one
//   ST_SEND | presenting hold byte[idx]; last handoff may chain the next word
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst_n,
  byte_serializer_if.slave bus
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] mux_byte;
  logic              is_last;
  logic              accept;
  logic              handoff;
  logic              ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    is_last = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    handoff = (state_q == ST_SEND) && bus.out_ready;
    // Ready only when the current word is guaranteed to leave this edge.
    ready   = (state_q == ST_IDLE) || (is_last && bus.out_ready);
    accept  = bus.in_valid && ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          idx_d   = '0;
          hold_d  = pack_word(bus.B1, bus.B2, bus.B3, bus.B4, LSB_FIRST);
        end
      end
      ST_SEND: begin
        if (handoff) begin
          if (!is_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (accept) begin
              idx_d  = '0;
              hold_d = pack_word(bus.B1, bus.B2, bus.B3, bus.B4, LSB_FIRST);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  byte_serializer_byte_mux u_byte_mux (
    .word (hold_q),
    .sel  (idx_q),
    .data (mux_byte)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == ST_SEND);
  assign bus.out_data  = (state_q == ST_SEND) ? mux_byte : '0;
  assign bus.out_last  = (state_q == ST_SEND) && is_last;
  assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Drives three serializer variants with shared stimulus and checks against a byte-queue model.
module tb_byte_serializer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] b1, b2, b3, b4;

  int checks;
  int errors;

  // Reference: pending bytes of the word in flight, in emission order.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [15:0] cnt0;
  logic [1:0]  cnt2;

  byte_serializer_if #(.CNT_W(16)) if0 ();
  byte_serializer_if #(.CNT_W(16)) if1 ();
  byte_serializer_if #(.CNT_W(2))  if2 ();

  assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
  assign if0.B1 = b1;  assign if0.B2 = b2;  assign if0.B3 = b3;  assign if0.B4 = b4;
  assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
  assign if1.B1 = b1;  assign if1.B2 = b2;  assign if1.B3 = b3;  assign if1.B4 = b4;
  assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;
  assign if2.B1 = b1;  assign if2.B2 = b2;  assign if2.B3 = b3;  assign if2.B4 = b4;

  byte_serializer #(.LSB_FIRST(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  byte_serializer #(.LSB_FIRST(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  byte_serializer #(.LSB_FIRST(1'b0), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_word(input logic [31:0] w);
    {b1, b2, b3, b4} = w;
  endtask

  // One clock edge; the model advances from the inputs held across that edge.
  task automatic tick();
    logic hand, acc;
    hand = (q0.size() != 0) && out_ready;
    acc  = in_valid && ((q0.size() == 0) || ((q0.size() == 1) && out_ready));
    @(posedge clk);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      cnt0 = '0;
      cnt2 = '0;
    end else begin
      if (hand) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) begin
          cnt0 = cnt0 + 16'd1;
          cnt2 = cnt2 + 2'd1;
        end
      end
      if (acc) begin
        q0.push_back(b1); q0.push_back(b2); q0.push_back(b3); q0.push_back(b4);
        q1.push_back(b4); q1.push_back(b3); q1.push_back(b2); q1.push_back(b1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_word(32'h0);
    tick(); tick();
    #1;
    checks++;
    if ({if0.out_data, if0.out_valid, if0.out_last} !== 10'd0 || if0.word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_dut0: got data=%0h valid=%0b last=%0b cnt=%0d, expected all 0",
               if0.out_data, if0.out_valid, if0.out_last, if0.word_cnt);
    end
    checks++;
    if ({if1.out_data, if1.out_valid, if1.out_last} !== 10'd0 || if1.word_cnt !== 16'd0 ||
        {if2.out_data, if2.out_valid, if2.out_last} !== 10'd0 || if2.word_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut1_2: got d1=%0h v1=%0b c1=%0d d2=%0h v2=%0b c2=%0d, expected all 0",
               if1.out_data, if1.out_valid, if1.word_cnt, if2.out_data, if2.out_valid, if2.word_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [7:0] exp0[4];
    logic [7:0] exp1[4];
    logic [15:0] start;
    exp0 = '{8'hFE, 8'hFC, 8'hF8, 8'hF0};
    exp1 = '{8'hF0, 8'hF8, 8'hFC, 8'hFE};
    start = cnt0;
    in_valid = 1'b1; out_ready = 1'b1; set_word(32'hFEFCF8F0);
    #1;
    checks++;
    if (if0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle_ready: got %0b expected 1", if0.in_ready);
    end
    tick();
    in_valid = 1'b0; set_word($urandom);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== exp0[i] || if0.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_msb_byte%0d: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                 i, if0.out_valid, if0.out_data, if0.out_last, exp0[i], (i == 3));
      end
      checks++;
      if (if1.out_valid !== 1'b1 || if1.out_data !== exp1[i] || if1.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_lsb_byte%0d: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                 i, if1.out_valid, if1.out_data, if1.out_last, exp1[i], (i == 3));
      end
      tick();
    end
    #1;
    checks++;
    if (if0.out_valid !== 1'b0 || if0.word_cnt !== start + 16'd1) begin
      errors++;
      $display("FAIL single_done: got v=%0b cnt=%0d expected v=0 cnt=%0d",
               if0.out_valid, if0.word_cnt, start + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[8];
    logic [15:0] start;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start = cnt0;
    in_valid = 1'b1; out_ready = 1'b1; set_word(32'h11223344);
    tick();
    set_word(32'hAABBCCDD);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== exp[k] || if0.in_ready !== (k == 3 || k == 7)) begin
        errors++;
        $display("FAIL b2b_byte%0d: got v=%0b d=%0h rdy=%0b expected v=1 d=%0h rdy=%0b",
                 k, if0.out_valid, if0.out_data, if0.in_ready, exp[k], (k == 3 || k == 7));
      end
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    #1;
    checks++;
    if (if0.out_valid !== 1'b0 || if0.word_cnt !== start + 16'd2) begin
      errors++;
      $display("FAIL b2b_count: got v=%0b cnt=%0d expected v=0 cnt=%0d",
               if0.out_valid, if0.word_cnt, start + 16'd2);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] tail[3];
    tail = '{8'hFC, 8'hF8, 8'hF0};
    in_valid = 1'b1; out_ready = 1'b1; set_word(32'hFEFCF8F0);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1; set_word(32'h5A5A5A5A);
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== 8'hFC || if0.in_ready !== 1'b0 || if0.out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: got v=%0b d=%0h rdy=%0b l=%0b expected v=1 d=fc rdy=0 l=0",
                 s, if0.out_valid, if0.out_data, if0.in_ready, if0.out_last);
      end
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== tail[i] || if0.out_last !== (i == 2)) begin
        errors++;
        $display("FAIL resume%0d: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                 i, if0.out_valid, if0.out_data, if0.out_last, tail[i], (i == 2));
      end
      tick();
    end
    #1;
    checks++;
    if (if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume_idle: got v=%0b expected 0", if0.out_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp[4];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    in_valid = 1'b1; out_ready = 1'b1; set_word(32'hFEFCF8F0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (if0.out_valid !== 1'b0 || if0.out_data !== 8'h00 || if0.word_cnt !== 16'd0 || if0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: got v=%0b d=%0h cnt=%0d rdy=%0b expected v=0 d=0 cnt=0 rdy=1",
               if0.out_valid, if0.out_data, if0.word_cnt, if0.in_ready);
    end
    in_valid = 1'b1; set_word(32'h01020304);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== exp[i]) begin
        errors++;
        $display("FAIL post_reset_byte%0d: got v=%0b d=%0h expected v=1 d=%0h",
                 i, if0.out_valid, if0.out_data, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp[5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int w = 0; w < 5; w++) begin
      in_valid = 1'b1; set_word($urandom);
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      #1;
      checks++;
      if (if2.word_cnt !== exp[w]) begin
        errors++;
        $display("FAIL wrap_word%0d: got cnt=%0d expected %0d", w, if2.word_cnt, exp[w]);
      end
    end
  endtask

  task automatic test_random();
    logic       ev, el, er;
    logic [7:0] ed0, ed1;
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 7);
      set_word($urandom);
      #1;
      ev  = (q0.size() != 0);
      el  = (q0.size() == 1);
      er  = (q0.size() == 0) || ((q0.size() == 1) && out_ready);
      ed0 = ev ? q0[0] : 8'h00;
      ed1 = ev ? q1[0] : 8'h00;
      checks++;
      if (if0.out_valid !== ev || if0.out_data !== ed0 || if0.out_last !== el ||
          if0.in_ready !== er || if0.word_cnt !== cnt0) begin
        errors++;
        $display("FAIL rand_dut0 c=%0d: got v=%0b d=%0h l=%0b r=%0b n=%0d expected v=%0b d=%0h l=%0b r=%0b n=%0d",
                 c, if0.out_valid, if0.out_data, if0.out_last, if0.in_ready, if0.word_cnt,
                 ev, ed0, el, er, cnt0);
      end
      checks++;
      if (if1.out_valid !== ev || if1.out_data !== ed1 || if1.out_last !== el ||
          if1.in_ready !== er || if1.word_cnt !== cnt0) begin
        errors++;
        $display("FAIL rand_dut1 c=%0d: got v=%0b d=%0h l=%0b r=%0b n=%0d expected v=%0b d=%0h l=%0b r=%0b n=%0d",
                 c, if1.out_valid, if1.out_data, if1.out_last, if1.in_ready, if1.word_cnt,
                 ev, ed1, el, er, cnt0);
      end
      checks++;
      if (if2.out_data !== ed0 || if2.word_cnt !== cnt2) begin
        errors++;
        $display("FAIL rand_dut2 c=%0d: got d=%0h n=%0d expected d=%0h n=%0d",
                 c, if2.out_data, if2.word_cnt, ed0, cnt2);
      end
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt0 = '0;
    cnt2 = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_word(32'h0);
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
